// File: rtl/seq_pattern_detector_if.sv
// seq_pattern_detector_if: serial data, configuration and match status bundle for the pattern detector
interface seq_pattern_detector_if #(
  parameter int PAT_W = 2,
  parameter int CNT_W = 8
);
  logic A, a_valid, cfg_load, cfg_overlap, clr_count, Y;
  logic [PAT_W-1:0] cfg_pattern;
  logic [CNT_W-1:0] match_count;
  modport master (
    output A, a_valid, cfg_load, cfg_pattern, cfg_overlap, clr_count,
    input  Y, match_count
  );
  modport slave (
    input  A, a_valid, cfg_load, cfg_pattern, cfg_overlap, clr_count,
    output Y, match_count
  );
endinterface

// File: rtl/seq_pattern_detector.sv
// seq_pattern_detector: serial detector matching the last PAT_W valid bits against a loadable pattern
module seq_pattern_detector #(
  parameter int               PAT_W       = 2,
  parameter logic [PAT_W-1:0] RST_PATTERN = 2'b01,
  parameter logic             RST_OVERLAP = 1'b1,
  parameter int               CNT_W       = 8
) (
  input logic clk,
  input logic rst,
  seq_pattern_detector_if.slave bus
);
  localparam int FW = $clog2(PAT_W + 1);
  localparam logic [FW-1:0] EMPTY = '0;
  localparam logic [FW-1:0] ARMED = FW'(PAT_W);
  logic [PAT_W-1:0] pat_q, pat_d, hist_q, hist_d, nh;
  logic [FW-1:0] fill_q, fill_d, nf;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic ovl_q, ovl_d, y_q, match, flush;
  always_comb begin
    nh = {hist_q[PAT_W-2:0], bus.A};
    nf = (fill_q == ARMED) ? ARMED : fill_q + 1'b1;
    match = bus.a_valid && !bus.cfg_load && nf == ARMED && nh == pat_q;
    // non-overlapping mode restarts the history after every hit
    flush = bus.cfg_load || (match && !ovl_q);
    pat_d = bus.cfg_load ? bus.cfg_pattern : pat_q;
    ovl_d = bus.cfg_load ? bus.cfg_overlap : ovl_q;
    hist_d = flush ? '0 : bus.a_valid ? nh : hist_q;
    fill_d = flush ? EMPTY : bus.a_valid ? nf : fill_q;
    cnt_d = bus.clr_count ? '0 : (match && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q  <= RST_PATTERN;
      ovl_q  <= RST_OVERLAP;
      hist_q <= '0;
      fill_q <= EMPTY;
      y_q    <= 1'b0;
      cnt_q  <= '0;
    end else begin
      pat_q  <= pat_d;
      ovl_q  <= ovl_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      y_q    <= match;
      cnt_q  <= cnt_d;
    end
  end
  assign bus.Y = y_q;
  assign bus.match_count = cnt_q;
endmodule

// File: tb/tb_seq_pattern_detector.sv
// tb_seq_pattern_detector: directed checks of the pattern detector in three configurations
module tb_seq_pattern_detector;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;

  seq_pattern_detector_if #(.PAT_W(2), .CNT_W(8)) i2 ();
  seq_pattern_detector_if #(.PAT_W(4), .CNT_W(8)) i4 ();
  seq_pattern_detector_if #(.PAT_W(2), .CNT_W(2)) ic ();

  seq_pattern_detector #(.PAT_W(2), .RST_PATTERN(2'b01), .RST_OVERLAP(1'b1), .CNT_W(8))
    d2 (.clk(clk), .rst(rst), .bus(i2));
  seq_pattern_detector #(.PAT_W(4), .RST_PATTERN(4'b0001), .RST_OVERLAP(1'b1), .CNT_W(8))
    d4 (.clk(clk), .rst(rst), .bus(i4));
  seq_pattern_detector #(.PAT_W(2), .RST_PATTERN(2'b01), .RST_OVERLAP(1'b1), .CNT_W(2))
    dc (.clk(clk), .rst(rst), .bus(ic));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load4(input logic [3:0] p, input logic o);
    i4.cfg_load = 1'b1; i4.cfg_pattern = p; i4.cfg_overlap = o; i4.clr_count = 1'b1;
    tick();
    i4.cfg_load = 1'b0; i4.clr_count = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++;
    if ({i2.Y, i4.Y, ic.Y} !== 3'b000) begin
      fails++; $display("FAIL reset_y got %b exp 000", {i2.Y, i4.Y, ic.Y});
    end
    tests++;
    if (i2.match_count !== 8'd0 || i4.match_count !== 8'd0 || ic.match_count !== 2'd0) begin
      fails++; $display("FAIL reset_count got %0d/%0d/%0d exp 0/0/0", i2.match_count, i4.match_count, ic.match_count);
    end
  endtask

  task automatic test_default_01();
    logic [3:0] s = 4'b0101;
    logic [3:0] e = 4'b0101;
    i2.a_valid = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      i2.A = s[i];
      tick();
      tests++;
      if (i2.Y !== e[i]) begin
        fails++; $display("FAIL default01_y bit%0d got %b exp %b", 3 - i, i2.Y, e[i]);
      end
    end
    i2.a_valid = 1'b0;
    tests++;
    if (i2.match_count !== 8'd2) begin
      fails++; $display("FAIL default01_count got %0d exp 2", i2.match_count);
    end
  endtask

  task automatic test_overlap_modes();
    logic [6:0] s = 7'b1011011;
    logic [6:0] e1 = 7'b0001001;
    logic [6:0] e0 = 7'b0001000;
    for (int m = 1; m >= 0; m--) begin
      load4(4'b1011, m[0]);
      i4.a_valid = 1'b1;
      for (int i = 6; i >= 0; i--) begin
        i4.A = s[i];
        tick();
        tests++;
        if (i4.Y !== (m == 1 ? e1[i] : e0[i])) begin
          fails++; $display("FAIL ovl%0d_y bit%0d got %b exp %b", m, 7 - i, i4.Y, m == 1 ? e1[i] : e0[i]);
        end
      end
      i4.a_valid = 1'b0;
      tests++;
      if (i4.match_count !== (m == 1 ? 8'd2 : 8'd1)) begin
        fails++; $display("FAIL ovl%0d_count got %0d exp %0d", m, i4.match_count, m == 1 ? 2 : 1);
      end
    end
  endtask

  task automatic test_gap();
    i2.cfg_load = 1'b1; i2.cfg_pattern = 2'b01; i2.cfg_overlap = 1'b1;
    tick();
    i2.cfg_load = 1'b0;
    i2.a_valid = 1'b1; i2.A = 1'b0;
    tick();
    tests++;
    if (i2.Y !== 1'b0) begin
      fails++; $display("FAIL gap_first got %b exp 0", i2.Y);
    end
    i2.a_valid = 1'b0;
    for (int g = 0; g < 3; g++) begin
      i2.A = ~g[0];
      tick();
      tests++;
      if (i2.Y !== 1'b0) begin
        fails++; $display("FAIL gap_idle%0d got %b exp 0", g, i2.Y);
      end
    end
    i2.a_valid = 1'b1; i2.A = 1'b1;
    tick();
    tests++;
    if (i2.Y !== 1'b1) begin
      fails++; $display("FAIL gap_match got %b exp 1", i2.Y);
    end
    i2.a_valid = 1'b0;
    tick();
    tests++;
    if (i2.Y !== 1'b0 || i2.match_count !== 8'd3) begin
      fails++; $display("FAIL gap_after y=%b cnt=%0d exp y=0 cnt=3", i2.Y, i2.match_count);
    end
  endtask

  task automatic test_load_drops_bit();
    logic [3:0] s = 4'b1011;
    logic [3:0] e = 4'b0001;
    load4(4'b1011, 1'b1);
    i4.a_valid = 1'b1;
    for (int i = 3; i >= 1; i--) begin
      i4.A = s[i];
      tick();
    end
    i4.A = 1'b1; i4.cfg_load = 1'b1; i4.cfg_pattern = 4'b1011; i4.cfg_overlap = 1'b1;
    tick();
    i4.cfg_load = 1'b0;
    tests++;
    if (i4.Y !== 1'b0) begin
      fails++; $display("FAIL load_cycle_y got %b exp 0", i4.Y);
    end
    for (int i = 3; i >= 0; i--) begin
      i4.A = s[i];
      tick();
      tests++;
      if (i4.Y !== e[i]) begin
        fails++; $display("FAIL load_drop_y bit%0d got %b exp %b", 3 - i, i4.Y, e[i]);
      end
    end
    i4.a_valid = 1'b0;
  endtask

  task automatic test_saturate_clear();
    int m;
    ic.a_valid = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      ic.A = (j % 2 == 0);
      tick();
      m = (j / 2 > 3) ? 3 : j / 2;
      tests++;
      if (ic.Y !== (j % 2 == 0) || ic.match_count !== m[1:0]) begin
        fails++; $display("FAIL sat_bit%0d y=%b cnt=%0d exp y=%b cnt=%0d", j, ic.Y, ic.match_count, j % 2 == 0, m);
      end
    end
    ic.A = 1'b0;
    tick();
    ic.A = 1'b1; ic.clr_count = 1'b1;
    tick();
    ic.clr_count = 1'b0; ic.a_valid = 1'b0;
    tests++;
    if (ic.Y !== 1'b1 || ic.match_count !== 2'd0) begin
      fails++; $display("FAIL clr_wins y=%b cnt=%0d exp y=1 cnt=0", ic.Y, ic.match_count);
    end
  endtask

  task automatic test_reset_mid();
    i2.cfg_load = 1'b1; i2.cfg_pattern = 2'b11; i2.cfg_overlap = 1'b0;
    tick();
    i2.cfg_load = 1'b0;
    i2.a_valid = 1'b1; i2.A = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++;
    if (i2.Y !== 1'b0 || i2.match_count !== 8'd0) begin
      fails++; $display("FAIL rst_mid y=%b cnt=%0d exp y=0 cnt=0", i2.Y, i2.match_count);
    end
    i2.A = 1'b1;
    tick();
    tests++;
    if (i2.Y !== 1'b0) begin
      fails++; $display("FAIL rst_hist_lost got %b exp 0", i2.Y);
    end
    i2.A = 1'b0;
    tick();
    i2.A = 1'b1;
    tick();
    i2.a_valid = 1'b0;
    tests++;
    if (i2.Y !== 1'b1 || i2.match_count !== 8'd1) begin
      fails++; $display("FAIL rst_pattern01 y=%b cnt=%0d exp y=1 cnt=1", i2.Y, i2.match_count);
    end
  endtask

  initial begin
    {i2.A, i2.a_valid, i2.cfg_load, i2.cfg_overlap, i2.clr_count} = '0; i2.cfg_pattern = '0;
    {i4.A, i4.a_valid, i4.cfg_load, i4.cfg_overlap, i4.clr_count} = '0; i4.cfg_pattern = '0;
    {ic.A, ic.a_valid, ic.cfg_load, ic.cfg_overlap, ic.clr_count} = '0; ic.cfg_pattern = '0;
    #2;
    test_reset();
    test_default_01();
    test_overlap_modes();
    test_gap();
    test_load_drops_bit();
    test_saturate_clear();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
